// File: rtl/iir_mac_sequencer.sv
// Control sequencer for a single shared MAC running a direct-form IIR filter.
// Walks the feed-forward taps and then the feedback taps once per accepted sample.
// Waits out the MAC pipeline, then strobes the result into data_out and the feedback history.
// Holds one early sample in a pending buffer and keeps a sticky flag when a sample is dropped.
module iir_mac_sequencer #(
  parameter int unsigned FF_TAP_COUNT = 7,
  parameter int unsigned FB_TAP_COUNT = 7,
  parameter int unsigned MAC_LATENCY  = 2,
  parameter int unsigned ADDR_W       = $clog2(FF_TAP_COUNT + FB_TAP_COUNT),
  parameter int unsigned TAP_W        =
    (((FF_TAP_COUNT > FB_TAP_COUNT) ? FF_TAP_COUNT : FB_TAP_COUNT) > 1) ?
    $clog2((FF_TAP_COUNT > FB_TAP_COUNT) ? FF_TAP_COUNT : FB_TAP_COUNT) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic              overrun_clr,
  output logic              sample_latch,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              hist_sel,
  output logic [TAP_W-1:0]  tap_idx,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              out_valid,
  output logic              fb_push,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned TAP_MAX = (FF_TAP_COUNT > FB_TAP_COUNT) ? FF_TAP_COUNT : FB_TAP_COUNT;
  localparam int unsigned CNT_MAX = (TAP_MAX > MAC_LATENCY) ? TAP_MAX : MAC_LATENCY;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    FF    = 3'd2,
    FB    = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               overrun_d;
  logic               consume;
  logic               drop;

  logic               sample_latch_d;
  logic               mac_en_d;
  logic               hist_sel_d;
  logic [TAP_W-1:0]   tap_idx_d;
  logic [ADDR_W-1:0]  coeff_addr_d;
  logic               out_valid_d;
  logic               busy_d;

  // Next state, tap counter, pending/overrun bookkeeping and next-cycle output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    consume   = 1'b0;
    drop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && (sample_valid || pending_q)) begin
          state_d = LATCH;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        state_d = FF;
        cnt_d   = '0;
      end
      FF: begin
        if (cnt_q == CNT_W'(FF_TAP_COUNT - 1)) begin
          state_d = FB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FB: begin
        if (cnt_q == CNT_W'(FB_TAP_COUNT - 1)) begin
          state_d = (MAC_LATENCY == 0) ? DONE : DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(MAC_LATENCY - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = (pending_q && enable) ? LATCH : IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A buffered sample is consumed whenever it starts the next LATCH.
    consume = pending_q && enable && ((state_q == IDLE) || (state_q == DONE));

    if (state_q != IDLE) begin
      drop      = sample_valid && pending_q && !consume;
      pending_d = sample_valid || (pending_q && !consume);
    end else if (enable) begin
      // In IDLE a live sample starts directly; it only gets buffered if the pending one goes first.
      pending_d = pending_q && sample_valid;
    end

    overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun);

    sample_latch_d = (state_d == LATCH);
    mac_en_d       = (state_d == FF) || (state_d == FB);
    hist_sel_d     = (state_d == FB);
    tap_idx_d      = mac_en_d ? TAP_W'(cnt_d) : '0;
    coeff_addr_d   = '0;
    if (state_d == FF) begin
      coeff_addr_d = ADDR_W'(cnt_d);
    end else if (state_d == FB) begin
      coeff_addr_d = ADDR_W'(FF_TAP_COUNT) + ADDR_W'(cnt_d);
    end
    out_valid_d    = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // State, counter, flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      overrun      <= 1'b0;
      sample_latch <= 1'b0;
      mac_clear    <= 1'b0;
      mac_en       <= 1'b0;
      hist_sel     <= 1'b0;
      tap_idx      <= '0;
      coeff_addr   <= '0;
      out_valid    <= 1'b0;
      fb_push      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      overrun      <= overrun_d;
      sample_latch <= sample_latch_d;
      mac_clear    <= sample_latch_d;
      mac_en       <= mac_en_d;
      hist_sel     <= hist_sel_d;
      tap_idx      <= tap_idx_d;
      coeff_addr   <= coeff_addr_d;
      out_valid    <= out_valid_d;
      fb_push      <= out_valid_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Self-checking bench: two sequencer configurations (7/7/2 and 3/3/0) share one input stream.
// A phase-based reference model predicts every output on every cycle.
module tb_iir_mac_sequencer;

  localparam int unsigned A_FF = 7, A_FB = 7, A_LAT = 2;
  localparam int unsigned B_FF = 3, B_FB = 3, B_LAT = 0;

  logic clk = 1'b0;
  logic reset_n, enable, sample_valid, overrun_clr;

  logic       a_sample_latch, a_mac_clear, a_mac_en, a_hist_sel, a_out_valid, a_fb_push;
  logic       a_busy, a_overrun;
  logic [2:0] a_tap_idx;
  logic [3:0] a_coeff_addr;

  logic       b_sample_latch, b_mac_clear, b_mac_en, b_hist_sel, b_out_valid, b_fb_push;
  logic       b_busy, b_overrun;
  logic [1:0] b_tap_idx;
  logic [2:0] b_coeff_addr;

  iir_mac_sequencer #(.FF_TAP_COUNT(A_FF), .FB_TAP_COUNT(A_FB), .MAC_LATENCY(A_LAT)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .overrun_clr(overrun_clr), .sample_latch(a_sample_latch), .mac_clear(a_mac_clear),
    .mac_en(a_mac_en), .hist_sel(a_hist_sel), .tap_idx(a_tap_idx), .coeff_addr(a_coeff_addr),
    .out_valid(a_out_valid), .fb_push(a_fb_push), .busy(a_busy), .overrun(a_overrun));

  iir_mac_sequencer #(.FF_TAP_COUNT(B_FF), .FB_TAP_COUNT(B_FB), .MAC_LATENCY(B_LAT)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .overrun_clr(overrun_clr), .sample_latch(b_sample_latch), .mac_clear(b_mac_clear),
    .mac_en(b_mac_en), .hist_sel(b_hist_sel), .tap_idx(b_tap_idx), .coeff_addr(b_coeff_addr),
    .out_valid(b_out_valid), .fb_push(b_fb_push), .busy(b_busy), .overrun(b_overrun));

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: a sample in flight is described by its phase since the LATCH cycle.
  typedef struct {
    bit          active;
    int unsigned ph;
    bit          pend;
    bit          ovr;
  } mstate_t;

  typedef struct {
    int unsigned latch, mac_en, hist, tap, coeff, outv, busy, ovr;
  } mout_t;

  function automatic mstate_t model_step(input mstate_t m, input int unsigned ff,
                                         input int unsigned fb, input int unsigned lat,
                                         input bit rst_n, input bit en, input bit sv,
                                         input bit clr);
    mstate_t     r;
    int unsigned done_ph;
    bit          consume;
    bit          drop;
    r = m;
    done_ph = 1 + ff + fb + lat;
    if (!rst_n) begin
      r.active = 0; r.ph = 0; r.pend = 0; r.ovr = 0;
    end else if (m.active) begin
      consume = (m.ph == done_ph) && m.pend && en;
      drop    = sv && m.pend && !consume;
      r.pend  = sv || (m.pend && !consume);
      r.ovr   = drop ? 1'b1 : (clr ? 1'b0 : m.ovr);
      if (m.ph == done_ph) begin
        if (consume) r.ph = 0;
        else r.active = 0;
      end else begin
        r.ph = m.ph + 1;
      end
    end else begin
      r.ovr = clr ? 1'b0 : m.ovr;
      if (en && (sv || m.pend)) begin
        r.active = 1;
        r.ph     = 0;
        r.pend   = m.pend && sv;
      end
    end
    return r;
  endfunction

  function automatic mout_t model_out(input mstate_t m, input int unsigned ff,
                                      input int unsigned fb, input int unsigned lat);
    mout_t o;
    bit    tap;
    tap     = m.active && (m.ph >= 1) && (m.ph <= ff + fb);
    o.latch = (m.active && m.ph == 0) ? 1 : 0;
    o.mac_en = tap ? 1 : 0;
    o.hist  = (tap && m.ph > ff) ? 1 : 0;
    o.tap   = tap ? ((m.ph <= ff) ? m.ph - 1 : m.ph - 1 - ff) : 0;
    o.coeff = tap ? m.ph - 1 : 0;
    o.outv  = (m.active && m.ph == 1 + ff + fb + lat) ? 1 : 0;
    o.busy  = m.active ? 1 : 0;
    o.ovr   = m.ovr ? 1 : 0;
    return o;
  endfunction

  mstate_t ma = '{0, 0, 0, 0};
  mstate_t mb = '{0, 0, 0, 0};

  // One clock: advance both models with the sampled inputs, then compare all outputs.
  task automatic tick();
    mout_t ea, eb;
    @(posedge clk);
    ma = model_step(ma, A_FF, A_FB, A_LAT, reset_n, enable, sample_valid, overrun_clr);
    mb = model_step(mb, B_FF, B_FB, B_LAT, reset_n, enable, sample_valid, overrun_clr);
    #1;
    ea = model_out(ma, A_FF, A_FB, A_LAT);
    eb = model_out(mb, B_FF, B_FB, B_LAT);
    check("a.sample_latch", 32'(a_sample_latch), ea.latch);
    check("a.mac_clear",    32'(a_mac_clear),    ea.latch);
    check("a.mac_en",       32'(a_mac_en),       ea.mac_en);
    check("a.hist_sel",     32'(a_hist_sel),     ea.hist);
    check("a.tap_idx",      32'(a_tap_idx),      ea.tap);
    check("a.coeff_addr",   32'(a_coeff_addr),   ea.coeff);
    check("a.out_valid",    32'(a_out_valid),    ea.outv);
    check("a.fb_push",      32'(a_fb_push),      ea.outv);
    check("a.busy",         32'(a_busy),         ea.busy);
    check("a.overrun",      32'(a_overrun),      ea.ovr);
    check("b.sample_latch", 32'(b_sample_latch), eb.latch);
    check("b.mac_clear",    32'(b_mac_clear),    eb.latch);
    check("b.mac_en",       32'(b_mac_en),       eb.mac_en);
    check("b.hist_sel",     32'(b_hist_sel),     eb.hist);
    check("b.tap_idx",      32'(b_tap_idx),      eb.tap);
    check("b.coeff_addr",   32'(b_coeff_addr),   eb.coeff);
    check("b.out_valid",    32'(b_out_valid),    eb.outv);
    check("b.fb_push",      32'(b_fb_push),      eb.outv);
    check("b.busy",         32'(b_busy),         eb.busy);
    check("b.overrun",      32'(b_overrun),      eb.ovr);
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_sv();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  int unsigned lat_a, lat_b;

  initial begin
    reset_n = 1'b0; enable = 1'b1; sample_valid = 1'b0; overrun_clr = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(2);

    // Single sample: measure acceptance-to-out_valid latency independently of the model.
    lat_a = 0; lat_b = 0;
    pulse_sv();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (a_out_valid && lat_a == 0) lat_a = k + 1;
      if (b_out_valid && lat_b == 0) lat_b = k + 1;
    end
    check("latency_a", lat_a, 18);
    check("latency_b", lat_b, 8);

    // Second sample arrives while busy and is buffered.
    pulse_sv();
    run(4);
    pulse_sv();
    run(45);
    check("no_overrun_after_pending", 32'(a_overrun), 0);

    // Third sample during a full buffer is dropped; then cleared.
    pulse_sv();
    run(4);
    pulse_sv();
    run(1);
    pulse_sv();
    run(3);
    check("overrun_set", 32'(a_overrun), 1);
    run(45);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_cleared", 32'(a_overrun), 0);
    run(3);

    // Reset mid-sample abandons it.
    pulse_sv();
    run(9);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("busy_after_reset", 32'(a_busy), 0);
    run(40);

    // Enable low: ignored in IDLE, in-flight sample completes.
    enable = 1'b0;
    pulse_sv();
    run(5);
    check("idle_ignored", 32'(a_busy), 0);
    enable = 1'b1;
    pulse_sv();
    run(2);
    enable = 1'b0;
    run(25);
    enable = 1'b1;
    run(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 11) == 0);
      enable       = ($urandom_range(0, 19) != 0);
      overrun_clr  = ($urandom_range(0, 39) == 0);
      reset_n      = ($urandom_range(0, 599) != 0);
      tick();
    end
    sample_valid = 1'b0; overrun_clr = 1'b0; reset_n = 1'b1; enable = 1'b1;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
